mio_responder: RTL and testbench

- Memory/IO bus responder: the target end of the CPU's MIO handshake.
- Accepts the CPU's held read and write requests and serves them from an internal word RAM or a small peripheral register file.
- Signals completion with a one-cycle `mio_ready` pulse after a programmable number of wait states.
- Sits between the multi-cycle controller/datapath and on-chip memory/peripherals.

---
 rtl/mio_responder_if.sv | 20 ++
 rtl/mio_responder.sv | 140 ++++++++++++++
 tb/tb_mio_responder.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/mio_responder_if.sv
// MIO handshake bundle between the CPU (master) and the memory/IO responder (slave).
interface mio_responder_if;
  logic        cpu_mio;
  logic        mem_r;
  logic        mem_w;
  logic [31:0] addr_bus;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        mio_ready;

  modport master (
    output cpu_mio, mem_r, mem_w, addr_bus, data_in,
    input  data_out, mio_ready
  );

  modport slave (
    input  cpu_mio, mem_r, mem_w, addr_bus, data_in,
    output data_out, mio_ready
  );
endinterface

// File: rtl/mio_responder.sv
// MIO bus responder: word RAM plus LED/switch/cycle-counter registers, one-cycle ready pulse.
// Optional MIO_BUS_ERR_EN adds a bus_err pulse for unmapped, read-only-write or misaligned accesses.
module mio_responder #(
  parameter int unsigned RAM_AW    = 10,
  parameter int unsigned RD_WAIT   = 2,
  parameter int unsigned WR_WAIT   = 1,
  parameter string       INIT_FILE = ""
) (
  input  logic               clk,
  input  logic               reset_n,
  mio_responder_if.slave     bus,
  input  logic [15:0]        sw_in,
`ifdef MIO_BUS_ERR_EN
  output logic               bus_err,
`endif
  output logic [15:0]        led_out
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [31:0]        addr_q, wdata_q;
  logic               wr_q;
  logic [31:0]        data_out_q;
  logic               ready_q;
  logic [15:0]        led_q;
  logic [31:0]        cyc_q;
  logic [31:0]        mem [2**RAM_AW];

  logic               req, in_idle, go_done;
  logic [3:0]         wait_cnt;
  logic               cur_wr;
  logic [31:0]        cur_addr, cur_wdata, word_addr, rdata;
  logic [RAM_AW-1:0]  ram_idx;
  logic               is_ram, is_led, is_sw, is_cyc;
  logic               ram_we, led_we, cyc_clr, err;

  assign req      = bus.cpu_mio & (bus.mem_r | bus.mem_w);
  assign wait_cnt = bus.mem_w ? 4'(WR_WAIT) : 4'(RD_WAIT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= StIdle;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          if (wait_cnt == 4'd0) begin
            state_d = StDone;
          end else begin
            state_d = StBusy;
            cnt_d   = wait_cnt - 4'd1;
          end
        end
      end
      StBusy: begin
        if (cnt_q == 4'd0) state_d = StDone;
        else               cnt_d   = cnt_q - 4'd1;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // In IDLE a zero-wait access commits on its sampling edge, so use the live bus there.
  always_comb begin
    in_idle   = (state_q == StIdle);
    go_done   = (state_d == StDone) && (state_q != StDone);
    cur_wr    = in_idle ? bus.mem_w    : wr_q;
    cur_addr  = in_idle ? bus.addr_bus : addr_q;
    cur_wdata = in_idle ? bus.data_in  : wdata_q;
    word_addr = cur_addr & ~32'h3;
    ram_idx   = cur_addr[RAM_AW+1:2];
    is_ram    = (cur_addr[31:28] == 4'h0);
    is_led    = (word_addr == 32'hF000_0000);
    is_sw     = (word_addr == 32'hF000_0004);
    is_cyc    = (word_addr == 32'hF000_0008);
    rdata     = 32'h0;
    if (is_ram)      rdata = mem[ram_idx];
    else if (is_led) rdata = {16'h0, led_q};
    else if (is_sw)  rdata = {16'h0, sw_in};
    else if (is_cyc) rdata = cyc_q;
    ram_we  = go_done & cur_wr & is_ram;
    led_we  = go_done & cur_wr & is_led;
    cyc_clr = go_done & cur_wr & is_cyc;
    err     = !(is_ram | is_led | is_sw | is_cyc) | (cur_wr & is_sw) | (cur_addr[1:0] != 2'b00);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q      <= 4'd0;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      wr_q       <= 1'b0;
      ready_q    <= 1'b0;
      data_out_q <= 32'h0;
      led_q      <= 16'h0;
      cyc_q      <= 32'h0;
    end else begin
      cnt_q   <= cnt_d;
      ready_q <= go_done;
      if (in_idle && req) begin
        addr_q  <= bus.addr_bus;
        wdata_q <= bus.data_in;
        wr_q    <= bus.mem_w;
      end
      if (go_done && !cur_wr) data_out_q <= rdata;
      if (led_we)             led_q      <= cur_wdata[15:0];
      if (cyc_clr)            cyc_q      <= 32'h0;
      else                    cyc_q      <= cyc_q + 32'd1;
    end
  end

  // RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_idx] <= cur_wdata;
  end

`ifdef MIO_BUS_ERR_EN
  logic err_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) err_q <= 1'b0;
    else          err_q <= go_done & err;
  end
  assign bus_err = err_q;
`else
  logic unused_err;
  assign unused_err = err;
`endif

  assign bus.data_out  = data_out_q;
  assign bus.mio_ready = ready_q;
  assign led_out       = led_q;

endmodule

// File: tb/tb_mio_responder.sv
// Directed, table-driven bench for mio_responder with hand sequences for the cycle counter
// and reset during a wait state.
module tb_mio_responder;

  localparam int RD_W = 2;
  localparam int WR_W = 1;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] sw_in = 16'h0;
  logic [15:0] led_out;
`ifdef MIO_BUS_ERR_EN
  logic        bus_err;
`endif

  mio_responder_if bus ();

  mio_responder #(
    .RAM_AW   (10),
    .RD_WAIT  (RD_W),
    .WR_WAIT  (WR_W),
    .INIT_FILE("")
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus),
    .sw_in  (sw_in),
`ifdef MIO_BUS_ERR_EN
    .bus_err(bus_err),
`endif
    .led_out(led_out)
  );

  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    logic [15:0] exp_led;
    logic        exp_err;
  } vec_t;

  vec_t vecs[18];

  function automatic vec_t mk(input logic rd, input logic wr, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] exp_data,
                              input logic [15:0] exp_led, input logic exp_err);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata;
    v.exp_data = exp_data; v.exp_led = exp_led; v.exp_err = exp_err;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // One CPU access; request is held through the DONE cycle to prove no second pulse.
  task automatic access(input string name, input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic chk_data, input logic [31:0] exp_data,
                        input logic [15:0] exp_led, input logic exp_err,
                        output logic [31:0] got_data, output int commit_edge);
    int n;
    int w;
    logic got;
    w = wr ? WR_W : RD_W;
    @(negedge clk);
    bus.cpu_mio  = 1'b1;
    bus.mem_r    = rd;
    bus.mem_w    = wr;
    bus.addr_bus = addr;
    bus.data_in  = wdata;
    n   = 0;
    got = 1'b0;
    while (n < 40 && !got) begin
      @(negedge clk);
      n++;
      if (bus.mio_ready === 1'b1) got = 1'b1;
    end
    check({name, " latency"}, 32'(n), 32'(w + 1));
    got_data    = bus.data_out;
    commit_edge = edge_n;
    if (chk_data) check({name, " data"}, bus.data_out, exp_data);
    check({name, " led"}, {16'h0, led_out}, {16'h0, exp_led});
`ifdef MIO_BUS_ERR_EN
    check({name, " bus_err"}, {31'h0, bus_err}, {31'h0, exp_err});
`else
    if (exp_err === 1'bx) $display("note: unexpected X flag in %s", name);
`endif
    @(negedge clk);
    check({name, " one-cycle pulse"}, {31'h0, bus.mio_ready}, 32'h0);
    bus.cpu_mio = 1'b0;
    bus.mem_r   = 1'b0;
    bus.mem_w   = 1'b0;
    @(negedge clk);
    check({name, " no repeat"}, {31'h0, bus.mio_ready}, 32'h0);
  endtask

  initial begin
    logic [31:0] d;
    int          ce, clr_edge, rd_edge;

    vecs[0]  = mk(0, 1, 32'h0000_0000, 32'hDEAD_BEEF, 32'h0000_0000, 16'h0000, 0);
    vecs[1]  = mk(1, 0, 32'h0000_0000, 32'h0,         32'hDEAD_BEEF, 16'h0000, 0);
    vecs[2]  = mk(0, 1, 32'h0000_0010, 32'h1234_5678, 32'hDEAD_BEEF, 16'h0000, 0);
    vecs[3]  = mk(1, 0, 32'h0000_0010, 32'h0,         32'h1234_5678, 16'h0000, 0);
    vecs[4]  = mk(1, 0, 32'h0000_1010, 32'h0,         32'h1234_5678, 16'h0000, 0);
    vecs[5]  = mk(0, 1, 32'hF000_0000, 32'h0000_A5A5, 32'h1234_5678, 16'hA5A5, 0);
    vecs[6]  = mk(1, 0, 32'hF000_0000, 32'h0,         32'h0000_A5A5, 16'hA5A5, 0);
    vecs[7]  = mk(1, 0, 32'hF000_0004, 32'h0,         32'h0000_00FF, 16'hA5A5, 0);
    vecs[8]  = mk(0, 1, 32'hF000_0004, 32'h0000_FFFF, 32'h0000_00FF, 16'hA5A5, 1);
    vecs[9]  = mk(1, 0, 32'h8000_0000, 32'h0,         32'h0000_0000, 16'hA5A5, 1);
    vecs[10] = mk(1, 0, 32'hF000_000C, 32'h0,         32'h0000_0000, 16'hA5A5, 1);
    vecs[11] = mk(1, 1, 32'h0000_0004, 32'h0000_0055, 32'h0000_0000, 16'hA5A5, 0);
    vecs[12] = mk(1, 0, 32'h0000_0004, 32'h0,         32'h0000_0055, 16'hA5A5, 0);
    vecs[13] = mk(1, 0, 32'h0000_0003, 32'h0,         32'hDEAD_BEEF, 16'hA5A5, 1);
    vecs[14] = mk(0, 1, 32'h1000_0010, 32'hCAFE_F00D, 32'hDEAD_BEEF, 16'hA5A5, 1);
    vecs[15] = mk(1, 0, 32'h0000_0010, 32'h0,         32'h1234_5678, 16'hA5A5, 0);
    vecs[16] = mk(0, 1, 32'h0000_0020, 32'h1111_1111, 32'h1234_5678, 16'hA5A5, 0);
    vecs[17] = mk(1, 0, 32'h0000_0020, 32'h0,         32'h1111_1111, 16'hA5A5, 0);

    bus.cpu_mio  = 1'b0;
    bus.mem_r    = 1'b0;
    bus.mem_w    = 1'b0;
    bus.addr_bus = 32'h0;
    bus.data_in  = 32'h0;
    sw_in        = 16'h00FF;

    repeat (3) @(negedge clk);
    check("reset mio_ready", {31'h0, bus.mio_ready}, 32'h0);
    check("reset data_out", bus.data_out, 32'h0);
    check("reset led_out", {16'h0, led_out}, 32'h0);
    reset_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      access($sformatf("vec%0d", i), vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
             1'b1, vecs[i].exp_data, vecs[i].exp_led, vecs[i].exp_err, d, ce);
    end

    // Cycle counter: value read = edges elapsed after the clearing commit edge, minus one.
    access("cyc read0", 1'b1, 1'b0, 32'hF000_0008, 32'h0, 1'b0, 32'h0, 16'hA5A5, 1'b0, d, ce);
    repeat (10) @(negedge clk);
    access("cyc clear", 1'b0, 1'b1, 32'hF000_0008, 32'h1234, 1'b0, 32'h0, 16'hA5A5, 1'b0,
           d, clr_edge);
    access("cyc read1", 1'b1, 1'b0, 32'hF000_0008, 32'h0, 1'b0, 32'h0, 16'hA5A5, 1'b0,
           d, rd_edge);
    check("cyc count", d, 32'(rd_edge - clr_edge - 1));

    // Reset while a write to word 8 is waiting in BUSY.
    @(negedge clk);
    bus.cpu_mio  = 1'b1;
    bus.mem_w    = 1'b1;
    bus.addr_bus = 32'h0000_0020;
    bus.data_in  = 32'h2222_2222;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("rst mid ready", {31'h0, bus.mio_ready}, 32'h0);
    @(negedge clk);
    check("rst held ready", {31'h0, bus.mio_ready}, 32'h0);
    check("rst led", {16'h0, led_out}, 32'h0);
    check("rst data_out", bus.data_out, 32'h0);
    bus.cpu_mio = 1'b0;
    bus.mem_w   = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    access("post-rst read w8", 1'b1, 1'b0, 32'h0000_0020, 32'h0, 1'b1, 32'h1111_1111,
           16'h0000, 1'b0, d, ce);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
